// File: rtl/parking_slot_allocator.sv
// Parking slot allocator: tracks an occupancy map and hands out free slots
// on request, using either lowest-free-index or round-robin selection.
module parking_slot_allocator #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned IDX_W     = $clog2(NUM_SLOTS),
  parameter int unsigned CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rr_mode,
  input  logic                 enter_req,
  input  logic                 exit_req,
  input  logic [IDX_W-1:0]     exit_slot,
  output logic                 assign_valid,
  output logic [IDX_W-1:0]     assign_slot,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [CNT_W-1:0]     free_count,
  output logic                 full,
  output logic                 empty,
  output logic                 err
);

  logic [IDX_W-1:0]     last_slot;

  logic                 found;
  logic [IDX_W-1:0]     pick;
  logic [NUM_SLOTS-1:0] pick_mask;
  logic                 exit_hit;
  logic [NUM_SLOTS-1:0] exit_mask;

  logic                 enter_ok;
  logic                 exit_ok;
  logic [NUM_SLOTS-1:0] occupancy_n;
  logic [CNT_W-1:0]     free_count_n;
  logic                 full_n;
  logic                 empty_n;
  logic                 assign_valid_n;
  logic [IDX_W-1:0]     assign_slot_n;
  logic [IDX_W-1:0]     last_slot_n;
  logic                 err_n;

  // Free-slot search over the pre-edge map; round-robin starts after last_slot.
  always_comb begin
    int unsigned start;
    int unsigned probe;
    found     = 1'b0;
    pick      = '0;
    pick_mask = '0;
    start     = 0;
    probe     = 0;
    if (rr_mode && (32'(last_slot) + 32'd1 < NUM_SLOTS)) begin
      start = 32'(last_slot) + 32'd1;
    end
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      probe = start + i;
      if (probe >= NUM_SLOTS) begin
        probe = probe - NUM_SLOTS;
      end
      if (!found && !occupancy[IDX_W'(probe)]) begin
        found     = 1'b1;
        pick      = IDX_W'(probe);
        pick_mask = NUM_SLOTS'(1) << probe;
      end
    end
  end

  // Exit lookup; an index beyond the lot never matches and so reads as free.
  always_comb begin
    exit_hit  = 1'b0;
    exit_mask = '0;
    for (int unsigned j = 0; j < NUM_SLOTS; j++) begin
      if (exit_slot == IDX_W'(j)) begin
        exit_hit     = occupancy[j];
        exit_mask[j] = 1'b1;
      end
    end
  end

  always_comb begin
    enter_ok       = enter_req && found;
    exit_ok        = exit_req && exit_hit;
    occupancy_n    = (occupancy | (enter_ok ? pick_mask : '0)) & ~(exit_ok ? exit_mask : '0);
    free_count_n   = free_count - CNT_W'(enter_ok) + CNT_W'(exit_ok);
    full_n         = (free_count_n == '0);
    empty_n        = (free_count_n == CNT_W'(NUM_SLOTS));
    assign_valid_n = enter_ok;
    assign_slot_n  = assign_slot;
    last_slot_n    = last_slot;
    if (enter_ok) begin
      assign_slot_n = pick;
      last_slot_n   = pick;
    end
    // One err pulse covers either or both rejected requests.
    err_n = (enter_req && !found) || (exit_req && !exit_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy    <= '0;
      free_count   <= CNT_W'(NUM_SLOTS);
      full         <= 1'b0;
      empty        <= 1'b1;
      assign_valid <= 1'b0;
      assign_slot  <= '0;
      last_slot    <= IDX_W'(NUM_SLOTS - 1);
      err          <= 1'b0;
    end else begin
      occupancy    <= occupancy_n;
      free_count   <= free_count_n;
      full         <= full_n;
      empty        <= empty_n;
      assign_valid <= assign_valid_n;
      assign_slot  <= assign_slot_n;
      last_slot    <= last_slot_n;
      err          <= err_n;
    end
  end

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Scoreboard bench for parking_slot_allocator: a driver pushes model predictions,
// a monitor pops and compares them one cycle later.
module tb_parking_slot_allocator;

  localparam int unsigned N = 8;

  typedef struct {
    logic [7:0] occ;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       av;
    logic [2:0] slot;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rr_mode = 1'b0;
  logic       enter_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [2:0] exit_slot = '0;
  logic       assign_valid;
  logic [2:0] assign_slot;
  logic [7:0] occupancy;
  logic [3:0] free_count;
  logic       full;
  logic       empty;
  logic       err;

  int checks = 0;
  int passed = 0;
  exp_t exp_q[$];

  // Reference model state: slot set, last allocated slot, held output index.
  bit m_occ[N];
  int m_last;
  int m_slot;

  parking_slot_allocator #(.NUM_SLOTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode), .enter_req(enter_req),
    .exit_req(exit_req), .exit_slot(exit_slot), .assign_valid(assign_valid),
    .assign_slot(assign_slot), .occupancy(occupancy), .free_count(free_count),
    .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    foreach (m_occ[i]) m_occ[i] = 1'b0;
    m_last = N - 1;
    m_slot = 0;
  endtask

  task automatic model_step(input bit en, input bit ex, input int unsigned es,
                            input bit mode, output exp_t e);
    int pick = -1;
    int start = mode ? (m_last + 1) % N : 0;
    int used = 0;
    bit ex_ok;
    for (int k = 0; k < N; k++) begin
      int s = (start + k) % N;
      if (pick < 0 && !m_occ[s]) pick = s;
    end
    ex_ok = ex && (es < N) && m_occ[es];
    e.err = (en && pick < 0) || (ex && !ex_ok);
    e.av  = en && pick >= 0;
    if (e.av) begin
      m_occ[pick] = 1'b1;
      m_last = pick;
      m_slot = pick;
    end
    if (ex_ok) m_occ[es] = 1'b0;
    e.occ = '0;
    for (int k = 0; k < N; k++) begin
      e.occ[k] = m_occ[k];
      used += m_occ[k];
    end
    e.cnt   = 4'(N - used);
    e.full  = (used == N);
    e.empty = (used == 0);
    e.slot  = 3'(m_slot);
  endtask

  task automatic drive(input bit en, input bit ex, input int unsigned es, input bit mode);
    exp_t e;
    @(negedge clk);
    enter_req = en;
    exit_req  = ex;
    exit_slot = 3'(es);
    rr_mode   = mode;
    model_step(en, ex, es, mode, e);
    exp_q.push_back(e);
  endtask

  task automatic settle();
    int n = 0;
    while (exp_q.size() != 0 && n < 5) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_occ"}, 64'(occupancy), 64'h0);
    check({tag, "_cnt"}, 64'(free_count), 64'd8);
    check({tag, "_empty"}, 64'(empty), 64'd1);
    check({tag, "_full"}, 64'(full), 64'd0);
    check({tag, "_av"}, 64'(assign_valid), 64'd0);
    check({tag, "_slot"}, 64'(assign_slot), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  // Called just after a drive: the pending prediction must never appear.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_vals("async_rst");
    enter_req = 1'b1;
    exit_req  = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("held_rst");
    @(negedge clk);
    rst_n     = 1'b1;
    enter_req = 1'b0;
    exit_req  = 1'b0;
    model_reset();
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("occupancy", 64'(occupancy), 64'(e.occ));
      check("free_count", 64'(free_count), 64'(e.cnt));
      check("full", 64'(full), 64'(e.full));
      check("empty", 64'(empty), 64'(e.empty));
      check("assign_valid", 64'(assign_valid), 64'(e.av));
      check("assign_slot", 64'(assign_slot), 64'(e.slot));
      check("err", 64'(err), 64'(e.err));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Mode 0 fill, overflow, exit/refill, full simultaneous enter+exit.
    repeat (8) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    settle();
    check("filled_occ", 64'(occupancy), 64'hFF);
    check("filled_cnt", 64'(free_count), 64'd0);
    check("filled_slot", 64'(assign_slot), 64'd7);
    drive(1, 0, 0, 0);
    drive(0, 1, 3, 0);
    drive(1, 0, 0, 0);
    drive(1, 1, 5, 0);
    drive(0, 0, 0, 0);
    settle();
    check("simul_occ", 64'(occupancy), 64'hDF);
    check("simul_cnt", 64'(free_count), 64'd1);

    // Mode 1 round-robin after a fresh reset.
    mid_reset();
    repeat (3) drive(1, 0, 0, 1);
    drive(0, 1, 0, 1);
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);
    settle();
    check("rr_skip_freed", 64'(assign_slot), 64'd3);
    repeat (5) drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);
    settle();
    check("rr_wrap", 64'(assign_slot), 64'd0);

    // Exit of a free slot on an empty lot.
    mid_reset();
    drive(0, 1, 2, 0);
    drive(0, 0, 0, 0);
    settle();
    check("free_exit_cnt", 64'(free_count), 64'd8);

    // Randomised traffic with mode flips and a mid-run reset.
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
            $urandom_range(0, 7), (c / 37) % 2 == 1 ? 1'b1 : ($urandom_range(0, 9) == 0));
      if (c == 211) mid_reset();
    end
    drive(0, 0, 0, 0);
    settle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
